// File: rtl/udma_clk_div_meas.sv
// -----------------------------------------------------------------------------
// udma_clk_div_meas
//   Recovers the integer divider ratio that produced an externally supplied,
//   asynchronous divided clock. Each half-period of clk_meas_i is timed in
//   clk_i cycles. After the partial first half-period is discarded, NUM_HP
//   consecutive half-periods must agree with the first one to within TOL
//   cycles before a result is published.
//
// Ports:
//   clk_i          system clock
//   rstn_i         asynchronous active-low reset
//   en_i           block enable; low aborts a running measurement
//   start_i        single-cycle request to begin a measurement
//   clk_meas_i     divided clock under measurement (asynchronous)
//   timeout_i      clk_i cycles to wait for the first edge, 0 = wait forever
//   busy_o         measurement in progress
//   div_o          last successfully measured divider value
//   div_valid_o    one-cycle pulse when div_o is updated
//   err_timeout_o  sticky: no edge seen within timeout_i
//   err_range_o    sticky: a half-period did not fit in CNT_W bits
//   err_mismatch_o sticky: half-periods differed by more than TOL
// -----------------------------------------------------------------------------
module udma_clk_div_meas #(
  parameter int CNT_W  = 8,
  parameter int NUM_HP = 4,
  parameter int TOL    = 1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             en_i,
  input  logic             start_i,
  input  logic             clk_meas_i,
  input  logic [15:0]      timeout_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] div_o,
  output logic             div_valid_o,
  output logic             err_timeout_o,
  output logic             err_range_o,
  output logic             err_mismatch_o
);

  localparam int HP_W = (NUM_HP > 2) ? $clog2(NUM_HP) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [HP_W-1:0]  HP_LAST = HP_W'(NUM_HP - 1);
  localparam logic [CNT_W:0]   TOL_EXT = (CNT_W + 1)'(TOL);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_t;

  state_t           r_state;
  logic [1:0]       r_sync;
  logic             r_dly;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_ref;
  logic [HP_W-1:0]  r_hp_idx;
  logic [15:0]      r_wdog;

  logic             meas_edge;
  logic [CNT_W:0]   hp_len;
  logic [CNT_W:0]   ref_ext;
  logic [CNT_W:0]   hp_diff;
  logic [16:0]      wdog_next;

  // Synchronizer plus edge-detect flop: both polarities of clk_meas_i count,
  // and the fixed pipeline delay leaves half-period lengths untouched.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_sync <= 2'b00;
      r_dly  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], clk_meas_i};
      r_dly  <= r_sync[1];
    end
  end

  assign meas_edge = r_sync[1] ^ r_dly;

  // One extra bit so a saturated counter plus the edge cycle (2^CNT_W) is
  // representable and recognised as out of range.
  assign hp_len    = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign ref_ext   = {1'b0, r_ref};
  assign hp_diff   = (hp_len >= ref_ext) ? (hp_len - ref_ext) : (ref_ext - hp_len);
  assign wdog_next = {1'b0, r_wdog} + 17'd1;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_ref          <= '0;
      r_hp_idx       <= '0;
      r_wdog         <= '0;
      busy_o         <= 1'b0;
      div_o          <= '0;
      div_valid_o    <= 1'b0;
      err_timeout_o  <= 1'b0;
      err_range_o    <= 1'b0;
      err_mismatch_o <= 1'b0;
    end else begin
      div_valid_o <= 1'b0;

      // Half-period counter: restarts on every edge and holds at its maximum
      // instead of wrapping.
      if (meas_edge) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (start_i && en_i) begin
            err_timeout_o  <= 1'b0;
            err_range_o    <= 1'b0;
            err_mismatch_o <= 1'b0;
            r_cnt          <= '0;
            r_wdog         <= '0;
            busy_o         <= 1'b1;
            r_state        <= ARM;
          end
        end

        ARM: begin
          if (!en_i) begin
            busy_o  <= 1'b0;
            r_state <= IDLE;
          end else if (meas_edge) begin
            // The edge closes the unknown partial half-period; timing starts here.
            r_hp_idx <= '0;
            r_state  <= MEAS;
          end else if ((timeout_i != 16'd0) && (wdog_next >= {1'b0, timeout_i})) begin
            err_timeout_o <= 1'b1;
            busy_o        <= 1'b0;
            r_state       <= IDLE;
          end else begin
            r_wdog <= wdog_next[15:0];
          end
        end

        MEAS: begin
          if (!en_i) begin
            busy_o  <= 1'b0;
            r_state <= IDLE;
          end else if (meas_edge) begin
            if (hp_len[CNT_W]) begin
              err_range_o <= 1'b1;
              busy_o      <= 1'b0;
              r_state     <= IDLE;
            end else if ((r_hp_idx != '0) && (hp_diff > TOL_EXT)) begin
              err_mismatch_o <= 1'b1;
              busy_o         <= 1'b0;
              r_state        <= IDLE;
            end else begin
              if (r_hp_idx == '0) begin
                r_ref <= hp_len[CNT_W-1:0];
              end
              if (r_hp_idx == HP_LAST) begin
                // NUM_HP >= 2, so r_ref was captured on an earlier edge.
                div_o       <= r_ref;
                div_valid_o <= 1'b1;
                busy_o      <= 1'b0;
                r_state     <= IDLE;
              end else begin
                r_hp_idx <= r_hp_idx + 1'b1;
              end
            end
          end else if (r_cnt == CNT_MAX) begin
            err_range_o <= 1'b1;
            busy_o      <= 1'b0;
            r_state     <= IDLE;
          end
        end

        default: begin
          busy_o  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_udma_clk_div_meas.sv
// -----------------------------------------------------------------------------
// tb_udma_clk_div_meas
//   Drives clk_meas_i from a half-period generator, runs table-driven and
//   randomized measurements, plus hand-written timeout / enable / reset cases.
// -----------------------------------------------------------------------------
module tb_udma_clk_div_meas;

  localparam int CNT_W  = 8;
  localparam int NUM_HP = 4;
  localparam int TOL    = 1;
  localparam int K_OK   = 0;
  localparam int K_MIS  = 1;
  localparam int K_RNG  = 2;

  logic             clk = 1'b0;
  logic             rstn_i = 1'b0;
  logic             en_i = 1'b1;
  logic             start_i = 1'b0;
  logic             clk_meas_i = 1'b0;
  logic [15:0]      timeout_i = 16'd0;
  logic             busy_o;
  logic [CNT_W-1:0] div_o;
  logic             div_valid_o;
  logic             err_timeout_o;
  logic             err_range_o;
  logic             err_mismatch_o;

  int n_tests = 0;
  int n_fail  = 0;
  int last_div = 0;

  // Half-period generator state
  bit gen_on = 1'b0;
  int gen_cnt = 0;
  int gen_cur = 5;
  int gen_d = 4;
  int hp_q[$];

  udma_clk_div_meas #(.CNT_W(CNT_W), .NUM_HP(NUM_HP), .TOL(TOL)) dut (
    .clk_i         (clk),
    .rstn_i        (rstn_i),
    .en_i          (en_i),
    .start_i       (start_i),
    .clk_meas_i    (clk_meas_i),
    .timeout_i     (timeout_i),
    .busy_o        (busy_o),
    .div_o         (div_o),
    .div_valid_o   (div_valid_o),
    .err_timeout_o (err_timeout_o),
    .err_range_o   (err_range_o),
    .err_mismatch_o(err_mismatch_o)
  );

  always #5 clk = ~clk;

  // Toggles clk_meas_i after gen_cur clk cycles, then takes the next length
  // from hp_q (or gen_d once the queue is empty).
  always @(negedge clk) begin
    if (gen_on) begin
      gen_cnt = gen_cnt + 1;
      if (gen_cnt >= gen_cur) begin
        clk_meas_i = ~clk_meas_i;
        gen_cnt = 0;
        if (hp_q.size() > 0) gen_cur = hp_q.pop_front();
        else gen_cur = gen_d;
      end
    end
  end

  typedef struct packed {
    logic [9:0] l0;
    logic [9:0] l1;
    logic [9:0] l2;
    logic [9:0] l3;
    logic [1:0] kind;
    logic [7:0] divv;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: outcome from the accepted half-period lengths alone.
  function automatic void model(input int l[4], output int kind, output int dv);
    kind = K_OK;
    dv = l[0];
    for (int i = 0; i < NUM_HP; i++) begin
      int d;
      if (l[i] > (1 << CNT_W) - 1) begin
        kind = K_RNG;
        return;
      end
      d = (l[i] > l[0]) ? l[i] - l[0] : l[0] - l[i];
      if (i > 0 && d > TOL) begin
        kind = K_MIS;
        return;
      end
    end
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
  endtask

  task automatic run_meas(input string tag, input int l[4], input int kind, input int dv);
    int nvalid;
    int vdiv;
    int done;
    nvalid = 0;
    vdiv = -1;
    done = 0;
    @(negedge clk);
    start_i = 1'b1;
    hp_q = {l[0], l[1], l[2], l[3]};
    gen_d = l[3];
    gen_cur = 5;
    gen_cnt = 0;
    gen_on = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      if (div_valid_o) begin
        nvalid++;
        vdiv = int'(div_o);
      end
      if (!busy_o) begin
        done = 1;
        break;
      end
    end
    check({tag, " done"}, done, 1);
    @(posedge clk);
    #1;
    if (div_valid_o) nvalid++;
    gen_on = 1'b0;
    check({tag, " valid_pulses"}, nvalid, (kind == K_OK) ? 1 : 0);
    if (kind == K_OK) begin
      check({tag, " valid_div"}, vdiv, dv);
      last_div = dv;
    end
    check({tag, " div_o"}, int'(div_o), last_div);
    check({tag, " err_mismatch"}, int'(err_mismatch_o), (kind == K_MIS) ? 1 : 0);
    check({tag, " err_range"}, int'(err_range_o), (kind == K_RNG) ? 1 : 0);
    check({tag, " err_timeout"}, int'(err_timeout_o), 0);
    $display("[TB] %s lens=%0d,%0d,%0d,%0d kind=%0d div_o=%0d", tag, l[0], l[1], l[2], l[3],
             kind, div_o);
    idle_cycles(6);
  endtask

  // Starts a long measurement and leaves it running in MEAS.
  task automatic start_long();
    @(negedge clk);
    start_i = 1'b1;
    hp_q = {20, 20, 20, 20};
    gen_d = 20;
    gen_cur = 5;
    gen_cnt = 0;
    gen_on = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    idle_cycles(30);
  endtask

  initial begin
    int l[4];
    int kind;
    int dv;
    int cnt;
    int nvalid;

    vecs[0]  = '{l0: 4,   l1: 4,   l2: 4,   l3: 4,   kind: K_OK,  divv: 4};
    vecs[1]  = '{l0: 1,   l1: 1,   l2: 1,   l3: 1,   kind: K_OK,  divv: 1};
    vecs[2]  = '{l0: 255, l1: 255, l2: 255, l3: 255, kind: K_OK,  divv: 255};
    vecs[3]  = '{l0: 10,  l1: 10,  l2: 13,  l3: 10,  kind: K_MIS, divv: 0};
    vecs[4]  = '{l0: 10,  l1: 11,  l2: 9,   l3: 10,  kind: K_OK,  divv: 10};
    vecs[5]  = '{l0: 256, l1: 256, l2: 256, l3: 256, kind: K_RNG, divv: 0};
    vecs[6]  = '{l0: 7,   l1: 8,   l2: 6,   l3: 7,   kind: K_OK,  divv: 7};
    vecs[7]  = '{l0: 7,   l1: 9,   l2: 7,   l3: 7,   kind: K_MIS, divv: 0};
    vecs[8]  = '{l0: 30,  l1: 31,  l2: 31,  l3: 29,  kind: K_OK,  divv: 30};
    vecs[9]  = '{l0: 2,   l1: 2,   l2: 2,   l3: 2,   kind: K_OK,  divv: 2};
    vecs[10] = '{l0: 3,   l1: 4,   l2: 3,   l3: 2,   kind: K_OK,  divv: 3};

    // Reset state
    idle_cycles(3);
    #1;
    check("rst busy", int'(busy_o), 0);
    check("rst div", int'(div_o), 0);
    check("rst valid", int'(div_valid_o), 0);
    check("rst err_timeout", int'(err_timeout_o), 0);
    check("rst err_range", int'(err_range_o), 0);
    check("rst err_mismatch", int'(err_mismatch_o), 0);
    @(negedge clk);
    rstn_i = 1'b1;
    idle_cycles(3);

    // start without enable is ignored
    @(negedge clk);
    en_i = 1'b0;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    idle_cycles(2);
    #1;
    check("start_no_en busy", int'(busy_o), 0);
    @(negedge clk);
    en_i = 1'b1;

    // Timeout: no edges, 100-cycle watchdog
    @(negedge clk);
    timeout_i = 16'd100;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    cnt = 0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      cnt++;
      if (!busy_o) break;
    end
    check("timeout cycles", cnt, 100);
    check("timeout flag", int'(err_timeout_o), 1);
    check("timeout valid", int'(div_valid_o), 0);
    $display("[TB] timeout busy_cycles=%0d err_timeout=%0d", cnt, err_timeout_o);
    @(negedge clk);
    timeout_i = 16'd0;

    // Table-driven vectors (first run also shows the timeout flag clearing)
    foreach (vecs[i]) begin
      l[0] = int'(vecs[i].l0);
      l[1] = int'(vecs[i].l1);
      l[2] = int'(vecs[i].l2);
      l[3] = int'(vecs[i].l3);
      run_meas($sformatf("vec%0d", i), l, int'(vecs[i].kind), int'(vecs[i].divv));
    end

    // A generous timeout must not fire when edges arrive
    timeout_i = 16'd1000;
    l = '{6, 6, 6, 6};
    run_meas("tmo_armed", l, K_OK, 6);
    timeout_i = 16'd0;

    // Randomized jitter around a base divider, checked against the model
    for (int r = 0; r < 20; r++) begin
      int base;
      base = int'($urandom_range(3, 80));
      for (int i = 0; i < 4; i++) l[i] = base + int'($urandom_range(0, 4)) - 2;
      model(l, kind, dv);
      run_meas($sformatf("rand%0d", r), l, kind, dv);
    end

    // Enable dropped mid-MEAS
    start_long();
    @(negedge clk);
    en_i = 1'b0;
    @(posedge clk);
    #1;
    check("en_drop busy", int'(busy_o), 0);
    nvalid = 0;
    for (int c = 0; c < 120; c++) begin
      @(posedge clk);
      #1;
      if (div_valid_o) nvalid++;
    end
    gen_on = 1'b0;
    check("en_drop valid", nvalid, 0);
    check("en_drop errs", int'({err_timeout_o, err_range_o, err_mismatch_o}), 0);
    check("en_drop div", int'(div_o), last_div);
    $display("[TB] en_drop busy=%0d div_o=%0d", busy_o, div_o);
    @(negedge clk);
    en_i = 1'b1;
    idle_cycles(5);

    // Reset asserted mid-MEAS
    start_long();
    @(negedge clk);
    rstn_i = 1'b0;
    #1;
    check("rst_mid busy", int'(busy_o), 0);
    check("rst_mid div", int'(div_o), 0);
    check("rst_mid valid", int'(div_valid_o), 0);
    check("rst_mid errs", int'({err_timeout_o, err_range_o, err_mismatch_o}), 0);
    $display("[TB] rst_mid busy=%0d div_o=%0d", busy_o, div_o);
    gen_on = 1'b0;
    last_div = 0;
    @(negedge clk);
    rstn_i = 1'b1;
    idle_cycles(5);

    l = '{5, 5, 6, 5};
    run_meas("after_rst", l, K_OK, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/udma_clk_div_meas.md
Name: udma_clk_div_meas

Overview:
- Receive-side counterpart of the integer clock divider counter.
- Samples an externally supplied divided clock, which is asynchronous to clk_i.
- Counts clk_i cycles per half-period over several consecutive half-periods and recovers the divider ratio that produced the clock.
- Used by uDMA peripherals for auto-baud / auto-clock detection and by verification self-checks of divider outputs.

Parameters:
- CNT_W, 8, width of measured divider value and half-period counter.
- NUM_HP, 4, number of consecutive half-periods that must agree before a result is declared (2..16).
- TOL, 1, maximum allowed absolute difference in clk_i cycles between any half-period and the first one.

Ports:
- clk_i  in  1  system clock.
- rstn_i  in  1  reset, asynchronous, active-low.
- en_i  in  1  block enable; low aborts any measurement.
- start_i  in  1  single-cycle request to begin a measurement.
- clk_meas_i  in  1  divided clock under measurement, asynchronous.
- timeout_i  in  16  maximum clk_i cycles to wait in ARM for the first edge; 0 = no timeout.
- busy_o  out  1  high while a measurement is in progress.
- div_o  out  CNT_W  last successfully measured divider value.
- div_valid_o  out  1  one-cycle pulse when div_o is updated.
- err_timeout_o  out  1  sticky: no edge seen within timeout_i.
- err_range_o  out  1  sticky: a half-period exceeded 2^CNT_W-1 cycles.
- err_mismatch_o  out  1  sticky: half-periods differed by more than TOL.

Behaviour:
- Reset values: all outputs 0; internal state IDLE; synchronizer flops 0.
- Input path: clk_meas_i -> 2-flop synchronizer -> edge-detect flop. edge = sync XOR delayed. Latency is a constant 3 cycles, so half-period lengths are unaffected. Both rising and falling edges count.
- r_cnt (CNT_W bits): cleared to 0 on every edge, otherwise increments. Half-period length is L = r_cnt + 1 at an edge, so a divider target D yields L = D.
- IDLE:
  - busy_o = 0.
  - When start_i && en_i: clear all three error flags, r_cnt = 0, watchdog = 0, go to ARM.
  - start_i without en_i is ignored.
- ARM:
  - busy_o = 1. Discards the partial first half-period.
  - On the first edge: r_cnt = 0, hp_idx = 0, go to MEAS.
  - If timeout_i != 0 and the watchdog reaches timeout_i with no edge: set err_timeout_o, go to IDLE.
- MEAS, on each edge:
  - If hp_idx == 0: r_ref = L.
  - Else if |L - r_ref| > TOL: set err_mismatch_o, go to IDLE. div_o is unchanged.
  - hp_idx increments. When NUM_HP half-periods have been accepted (hp_idx == NUM_HP-1 at that edge with no mismatch): div_o = r_ref, div_valid_o = 1 in the next cycle, go to IDLE.
- MEAS, no edge while r_cnt == 2^CNT_W-1: set err_range_o, go to IDLE. r_cnt never wraps.
- busy_o falls in the same cycle that div_valid_o or an error flag rises.
- en_i low in ARM or MEAS: return to IDLE next cycle. No valid pulse; error flags and div_o are unchanged.
- start_i while busy_o = 1: ignored.
- Edge in the same cycle as watchdog expiry in ARM: the edge wins (go to MEAS).
- Edge in the same cycle as r_cnt saturation in MEAS: the edge wins (L = 2^CNT_W, which is out of range). Set err_range_o.
- D = 1 (clock toggles every cycle): edges every cycle, L = 1, div_o = 1.
- Error flags are sticky until the next accepted start_i or reset.
- Asserting rstn_i mid-operation forces the reset values immediately.

Test Plan:
- Divider counter with target 4 drives clk_meas_i; pulse start_i -> after the ARM edge plus 4 half-periods of 4 cycles, div_o = 4, div_valid_o high exactly 1 cycle, busy_o low, all errors 0.
- Divider target 1 -> div_o = 1. Divider target 255 -> div_o = 255. No errors in either case.
- clk_meas_i held 0, timeout_i = 100, start_i -> err_timeout_o set and busy_o falls 100 cycles after ARM entry. A second start_i clears err_timeout_o.
- Half-periods 10, 10, 13 with TOL = 1 -> err_mismatch_o set at the third edge; div_o keeps its previous value; no valid pulse. Repeat with 10, 11, 9, 10 -> div_o = 10.
- Divider target 0 (256-cycle half-period) -> err_range_o set at r_cnt = 255; div_o unchanged.
- Drop en_i mid-MEAS -> IDLE next cycle, no valid pulse, no error flags. Assert rstn_i mid-MEAS -> all outputs 0 and busy_o = 0.
